// File: rtl/mux4_way_merge_if.sv
// Handshake bundle for the 4-way round-robin merge: four source channels in,
// one merged stream out. master = traffic source/sink side, slave = merge block.
interface mux4_way_merge_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] out;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output w, x, y, z, in_valid, out_ready,
    input  in_ready, out, sel, out_valid
  );

  modport slave (
    input  w, x, y, z, in_valid, out_ready,
    output in_ready, out, sel, out_valid
  );
endinterface

// File: rtl/mux4_way_merge.sv
// Round-robin merge of four valid/ready channels into one registered output
// stage; full throughput, grants decided combinationally from control only.
module mux4_way_merge #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  mux4_way_merge_if.slave bus
);

  logic [WIDTH-1:0] out_p1;
  logic [1:0]       sel_p1;
  logic             vld_p1;
  logic [1:0]       last;

  logic             load;
  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [WIDTH-1:0] data_p0;

  assign load = !vld_p1 || bus.out_ready;

  // Stage p0: search upward from last+1 so the most recent winner ranks lowest.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    data_p0 = bus.w;
    case (win)
      2'd0: data_p0 = bus.w;
      2'd1: data_p0 = bus.x;
      2'd2: data_p0 = bus.y;
      2'd3: data_p0 = bus.z;
      default: data_p0 = bus.w;
    endcase
  end

  always_comb begin
    bus.in_ready = 4'b0000;
    if (reset_n && load && found)
      bus.in_ready = 4'b0001 << win;
  end

  // Stage p1: output register; last=3 after reset puts channel 0 first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_p1 <= '0;
      sel_p1 <= 2'd0;
      vld_p1 <= 1'b0;
      last   <= 2'd3;
    end else if (load) begin
      if (found) begin
        out_p1 <= data_p0;
        sel_p1 <= win;
        vld_p1 <= 1'b1;
        last   <= win;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.out       = out_p1;
  assign bus.sel       = sel_p1;
  assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_mux4_way_merge.sv
// Directed bench for the 4-way round-robin merge with hand-computed expectations.
module tb_mux4_way_merge;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  mux4_way_merge_if #(.WIDTH(16)) bus ();

  mux4_way_merge #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d, input logic [1:0] s,
                         input logic v);
    chk({tag, ".out"}, 32'(bus.out), 32'(d));
    chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
    chk({tag, ".vld"}, 32'(bus.out_valid), 32'(v));
  endtask

  logic [15:0] dat [4];

  initial begin
    checks   = 0;
    failures = 0;
    dat[0] = 16'hA000; dat[1] = 16'hB001; dat[2] = 16'hC002; dat[3] = 16'hD003;

    reset_n = 1'b0;
    bus.w = 16'h0; bus.x = 16'h0; bus.y = 16'h0; bus.z = 16'h0;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    #12;
    chk_out("rst", 16'h0, 2'd0, 1'b0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'h0);
    bus.in_valid = 4'b0000;
    #2 reset_n = 1'b1;
    tick();

    // single word from channel 0
    bus.w = 16'h1234;
    bus.in_valid = 4'b0001;
    #1 chk("single.in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk_out("single", 16'h1234, 2'd0, 1'b1);

    // all channels valid: strict rotation 1,2,3,0 after channel 0
    bus.w = dat[0]; bus.x = dat[1]; bus.y = dat[2]; bus.z = dat[3];
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("rr%0d.in_ready", i), 32'(bus.in_ready), 32'(4'b0001 << ((i + 1) % 4)));
      tick();
      chk_out($sformatf("rr%0d", i), dat[(i + 1) % 4], 2'((i + 1) % 4), 1'b1);
    end

    // backpressure: word A000/sel 0 must stay put, no grants
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("hold%0d.in_ready", i), 32'(bus.in_ready), 32'h0);
      tick();
      chk_out($sformatf("hold%0d", i), dat[0], 2'd0, 1'b1);
    end
    bus.out_ready = 1'b1;
    #1 chk("release.in_ready", 32'(bus.in_ready), 32'h2);
    tick();
    chk_out("release", dat[1], 2'd1, 1'b1);

    // drain: valid drops one cycle after the last word leaves
    bus.in_valid = 4'b0000;
    #1 chk("drain.in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk_out("drain", dat[1], 2'd1, 1'b0);

    // last=1 with channels 3 and 0 pending: 3 wins, then wraps to 0
    bus.in_valid = 4'b1001;
    #1 chk("wrap3.in_ready", 32'(bus.in_ready), 32'h8);
    tick();
    chk_out("wrap3", dat[3], 2'd3, 1'b1);
    #1 chk("wrap0.in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk_out("wrap0", dat[0], 2'd0, 1'b1);

    // empty register accepts even with out_ready low
    bus.in_valid = 4'b0000;
    tick();
    chk("empty.vld", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0100;
    #1 chk("empty_load.in_ready", 32'(bus.in_ready), 32'h4);
    tick();
    chk_out("empty_load", dat[2], 2'd2, 1'b1);
    #1 chk("full_stall.in_ready", 32'(bus.in_ready), 32'h0);

    // asynchronous reset between edges while holding a word
    bus.in_valid = 4'b1111;
    #1 reset_n = 1'b0;
    #1 chk_out("areset", 16'h0, 2'd0, 1'b0);
    chk("areset.in_ready", 32'(bus.in_ready), 32'h0);
    #1 reset_n = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk("post_rst.in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk_out("post_rst", dat[0], 2'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
